// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational-read ROM among NUM_REQ requesters.
// A grant drives the ROM address and the read data lands in that requester's response register.
module rom_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_slice [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant_onehot;
  logic [IDX_W-1:0]      last_grant_reg;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_found;
  int                    scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_slice[gi]   = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      // A full response register blocks a new grant unless it drains this same cycle.
      assign eligible[gi]     = req_valid[gi] & (~rsp_valid_reg[gi] | rsp_ready[gi]);
      assign grant_onehot[gi] = grant_found && (grant_idx == IDX_W'(gi));
      assign rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] = rsp_data_reg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_data_reg[gi]  <= '0;
        end else if (grant_onehot[gi]) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_data_reg[gi]  <= rom_data;
        end else if (rsp_valid_reg[gi] && rsp_ready[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Scan starts just after the last winner and wraps, giving round-robin order.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = int'(last_grant_reg) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_found && eligible[scan_idx[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
    end else if (grant_found) begin
      last_grant_reg <= grant_idx;
    end
  end

  assign req_ready = grant_onehot;
  assign rsp_valid = rsp_valid_reg;
  assign rom_addr  = grant_found ? addr_slice[grant_idx] : '0;

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
Shares one single-port asynchronous (combinational-read) ROM among NUM_REQ requesters. Each requester has a valid/ready request channel and a valid/ready response channel. A round-robin scheduler grants at most one request per cycle and drives the shared ROM address. The ROM data is captured into the winner's response register, giving one-cycle latency and an aggregate throughput of one read per cycle. The block sits between requester ports and a ROM instance; the ROM itself is outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDR_WIDTH, 8, ROM address width
DATA_WIDTH, 8, ROM data width

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address; slice i is bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  output  NUM_REQ  per-requester grant/accept, at most one bit set
rsp_valid  output  NUM_REQ  per-requester response valid (registered)
rsp_data  output  NUM_REQ*DATA_WIDTH  per-requester response data (registered), sliced like req_addr
rsp_ready  input  NUM_REQ  per-requester response accept
rom_addr  output  ADDR_WIDTH  address to the shared asynchronous ROM
rom_data  input  DATA_WIDTH  combinational ROM read data for rom_addr

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid = 0 and rsp_data = 0 for all requesters.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation discards any pending responses. No state survives reset.
- Eligibility (combinational): requester i is eligible = req_valid[i] & (~rsp_valid[i] | rsp_ready[i]). A requester whose response register is full and not being drained is skipped.
- Arbitration (combinational):
  - Scan indices last_grant+1, last_grant+2, ... modulo NUM_REQ; the first eligible index is the grant g.
  - req_ready = one-hot(g), or all zero if no requester is eligible.
  - req_ready[i] may depend on req_valid[i]. Requesters must not make req_valid depend on req_ready.
- ROM drive: rom_addr = req_addr slice g when a grant exists, else 0. rom_data is sampled in the same cycle; the ROM path is purely combinational.
- Grant edge (transfer = req_valid[g] & req_ready[g]):
  - rsp_data[g] <= rom_data; rsp_valid[g] <= 1; last_grant <= g.
  - Response is visible the cycle after the request handshake (latency 1).
- Response drain: if rsp_valid[i] & rsp_ready[i] and i is not granted this cycle, then rsp_valid[i] <= 0. rsp_data holds its value; it is not cleared.
- Simultaneous drain and new grant to the same i: rsp_valid[i] stays 1 and rsp_data[i] takes the new value. This allows back-to-back reads at one per cycle.
- No grant: last_grant, rsp_valid and rsp_data hold, except for the drains above.
- Fairness: a continuously eligible requester is granted within NUM_REQ cycles.
- Each rsp_valid/rsp_data pair obeys valid/ready stability: once asserted, both hold until rsp_ready is sampled high.
- Pointer wrap: index NUM_REQ-1 is followed by index 0.
- An address outside the ROM depth is passed through unchanged; the ROM's behaviour defines the result.

Test Plan:
- ROM model mem[a] = a ^ 8'hA5, rsp_ready all 1. Reset, then req_valid[0]=1 with addr 8'h10 for one cycle -> req_ready = 4'b0001 that cycle; next cycle rsp_valid[0]=1 and rsp_data[0]=8'hB5; the cycle after, rsp_valid[0]=0.
- All four requesters valid continuously, addrs 1, 2, 3, 4 -> grants in order 0,1,2,3,0,... one per cycle; responses 8'hA4, 8'hA7, 8'hA6, 8'hA1.
- Requester 2 issues back-to-back addrs 8'h00 then 8'hFF, others idle -> granted on two consecutive cycles; rsp_data[2] = 8'hA5 then 8'h5A; rsp_valid[2] stays high throughout.
- Backpressure: rsp_ready[1]=0 with rsp_valid[1]=1 while req_valid[1]=1 and req_valid[3]=1 -> requester 1 is never granted and requester 3 is granted every cycle; rsp_data[1] is stable. Raise rsp_ready[1] -> requester 1 is granted in that same cycle and rsp_data[1] updates.
- Reset mid-operation: assert rst_n=0 between clock edges while rsp_valid=4'b1010 -> all rsp_valid drop immediately. After release, with all requesters valid, the first grant is requester 0.
- No requests for 10 cycles -> req_ready=0, rom_addr=0, and no state changes.
